// File: rtl/word_assembly_ctrl.sv
// word_assembly_ctrl
// Packs a byte stream into 32-bit words. Each accepted byte is driven, with its
// lane number, to an external byte-lane decoder that captures one edge later.
// Words close when four bytes are collected or on flush. A closed word passes
// through a one-cycle COMMIT and is then held until the consumer takes it.
//
// Optional feature: define WORD_ASM_TIMEOUT_EN to enable an 8-bit idle counter.
// The counter auto-flushes a partial word after TIMEOUT_CYCLES idle cycles and
// flags that word through word_timeout. Without the macro, word_timeout is tied low.

module word_assembly_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        byte_ready,
  input  logic        flush,
  output logic [1:0]  dec_sel,
  output logic [7:0]  dec_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [2:0]  word_bytes,
  output logic        word_timeout,
  output logic [15:0] word_cnt
);

  // Catch an out-of-range idle limit at elaboration, in every build.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("word_assembly_ctrl: TIMEOUT_CYCLES must be within 2..255");
  end

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    COMMIT = 2'd1,
    HOLD   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  dec_sel_q, dec_sel_d;
  logic [7:0]  dec_data_q, dec_data_d;
  logic        word_valid_q, word_valid_d;
  logic [2:0]  word_bytes_q, word_bytes_d;
  logic [15:0] word_cnt_q, word_cnt_d;

  logic        in_fill;
  logic        accept;
  logic [2:0]  pending;
  logic        word_full;
  logic        flush_go;
  logic        timeout_go;
  logic        close_word;
  logic        handoff;

  // Handshake and word-close conditions
  assign in_fill    = (state_q == FILL);
  assign byte_ready = in_fill & ~rst;
  assign accept     = byte_valid & byte_ready;
  // Bytes in the word including one accepted this cycle, so a flush that
  // coincides with an accept closes the word with that byte counted.
  assign pending    = {1'b0, lane_q} + {2'b00, accept};
  assign word_full  = accept & (lane_q == 2'd3);
  assign flush_go   = in_fill & flush & (pending != 3'd0);
  assign close_word = in_fill & (word_full | flush_go | timeout_go);
  assign handoff    = (state_q == HOLD) & word_ready;

`ifdef WORD_ASM_TIMEOUT_EN
  localparam logic [7:0] IdleLast = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] idle_q, idle_d;
  logic       word_timeout_q, word_timeout_d;

  // Idle limit reached on a partial word with no byte arriving this cycle
  assign timeout_go = in_fill & ~accept & (lane_q != 2'd0) & (idle_q == IdleLast);

  // Idle counter: runs only while a partial word waits in FILL
  always_comb begin
    idle_d = '0;
    if (in_fill && (lane_q != 2'd0) && !accept && !close_word) begin
      idle_d = idle_q + 8'd1;
    end
  end

  // Timeout flag captured when a word closes; an explicit flush or a full word wins
  always_comb begin
    word_timeout_d = word_timeout_q;
    if (close_word) begin
      word_timeout_d = timeout_go & ~word_full & ~flush_go;
    end
  end

  // Timeout-feature registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q         <= '0;
      word_timeout_q <= 1'b0;
    end else begin
      idle_q         <= idle_d;
      word_timeout_q <= word_timeout_d;
    end
  end

  assign word_timeout = word_timeout_q;
`else
  assign timeout_go   = 1'b0;
  assign word_timeout = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      lane_q       <= '0;
      dec_sel_q    <= '0;
      dec_data_q   <= '0;
      word_valid_q <= 1'b0;
      word_bytes_q <= '0;
      word_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      dec_sel_q    <= dec_sel_d;
      dec_data_q   <= dec_data_d;
      word_valid_q <= word_valid_d;
      word_bytes_q <= word_bytes_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (close_word) state_d = COMMIT;
      COMMIT:  state_d = HOLD;
      HOLD:    if (word_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Lane counter, decoder drive and word status next values
  always_comb begin
    lane_d       = lane_q;
    dec_sel_d    = dec_sel_q;
    dec_data_d   = dec_data_q;
    word_valid_d = word_valid_q;
    word_bytes_d = word_bytes_q;
    word_cnt_d   = word_cnt_q;

    // Decoder inputs only move on an accept, so a repeated capture is harmless.
    if (accept) begin
      dec_sel_d  = lane_q;
      dec_data_d = byte_in;
    end

    if (in_fill) begin
      if (close_word) begin
        lane_d       = '0;
        word_bytes_d = pending;
      end else if (accept) begin
        lane_d = lane_q + 2'd1;
      end
    end

    // Decoder has captured the final byte by the end of COMMIT.
    if (state_q == COMMIT) begin
      word_valid_d = 1'b1;
    end

    if (handoff) begin
      word_valid_d = 1'b0;
      lane_d       = '0;
      word_cnt_d   = word_cnt_q + 16'd1;
    end
  end

  assign dec_sel    = dec_sel_q;
  assign dec_data   = dec_data_q;
  assign word_valid = word_valid_q;
  assign word_bytes = word_bytes_q;
  assign word_cnt   = word_cnt_q;

endmodule
